// File: rtl/ecg_afe_pkg.sv
// Shared encodings, command opcodes and the AFE register configuration table
// for the ECG AFE sequencer. Readback states exist only with ECG_SEQ_READBACK_EN.
package ecg_afe_pkg;

    localparam logic [3:0] ST_PWRUP      = 4'd0;
    localparam logic [3:0] ST_CFG_REQ    = 4'd1;
    localparam logic [3:0] ST_CFG_REL    = 4'd2;
`ifdef ECG_SEQ_READBACK_EN
    localparam logic [3:0] ST_CFG_RB_REQ = 4'd3;
    localparam logic [3:0] ST_CFG_RB_REL = 4'd4;
`endif
    localparam logic [3:0] ST_IDLE       = 4'd5;
    localparam logic [3:0] ST_RD_REQ     = 4'd6;
    localparam logic [3:0] ST_RD_REL     = 4'd7;
    localparam logic [3:0] ST_ERROR      = 4'd8;

    typedef enum logic [3:0] {
        S_PWRUP      = ST_PWRUP,
        S_CFG_REQ    = ST_CFG_REQ,
        S_CFG_REL    = ST_CFG_REL,
`ifdef ECG_SEQ_READBACK_EN
        S_CFG_RB_REQ = ST_CFG_RB_REQ,
        S_CFG_RB_REL = ST_CFG_RB_REL,
`endif
        S_IDLE       = ST_IDLE,
        S_RD_REQ     = ST_RD_REQ,
        S_RD_REL     = ST_RD_REL,
        S_ERROR      = ST_ERROR
    } seq_state_t;

    localparam logic [31:0] READ_CMD_DEF = 32'h1200_0000;
    localparam logic [7:0]  RREG_BASE    = 8'h20;
    localparam logic [7:0]  WREG_BASE    = 8'h40;

    // Write word layout: {opcode|addr, 8'h00, data, 8'h00}
    function automatic logic [31:0] wreg_cmd(input logic [4:0] addr, input logic [7:0] data);
        return {WREG_BASE | {3'b000, addr}, 8'h00, data, 8'h00};
    endfunction

    function automatic logic [31:0] rreg_cmd(input logic [4:0] addr);
        return {RREG_BASE | {3'b000, addr}, 24'h00_0000};
    endfunction

    function automatic logic [31:0] cfg_table(input logic [3:0] idx);
        case (idx)
            4'd0:    return wreg_cmd(5'h01, 8'h02);  // CONFIG1: 500 SPS
            4'd1:    return wreg_cmd(5'h02, 8'hA0);  // CONFIG2: reference buffer on
            4'd2:    return wreg_cmd(5'h04, 8'h05);  // CH1SET: gain 6, test input
            4'd3:    return wreg_cmd(5'h05, 8'h81);  // CH2SET: powered down
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/ecg_afe_sequencer_if.sv
// Four-phase request/done handshake between the sequencer and the SPI master.
interface ecg_afe_sequencer_if;
    logic        spi_start;
    logic [31:0] spi_tx_data;
    logic [31:0] spi_rx_data;
    logic        spi_done;

    modport master (output spi_start, spi_tx_data, input spi_rx_data, spi_done);
    modport slave  (input spi_start, spi_tx_data, output spi_rx_data, spi_done);
endinterface

// File: rtl/ecg_drdy_sync.sv
// Two-flop synchronizer for the AFE data-ready pin plus a one-cycle falling-edge strobe.
module ecg_drdy_sync (
    input  logic clk,
    input  logic rst,
    input  logic drdy_n,
    output logic fall
);
    logic [1:0] sync;
    logic       prev;

    // Reset to the idle-high level so releasing reset never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
            prev <= 1'b1;
        end else begin
            sync <= {sync[0], drdy_n};
            prev <= sync[1];
        end
    end

    assign fall = prev & ~sync[1];
endmodule

// File: rtl/ecg_afe_sequencer.sv
// ECG AFE sequencer: power-up wait, register configuration, then one SPI read per drdy fall.
// Optional configuration readback check is enabled by defining ECG_SEQ_READBACK_EN.
//
// state      | meaning
// PWRUP      | power-up delay count
// CFG_REQ    | config write in flight
// CFG_REL    | waiting for done to drop after a write
// CFG_RB_REQ | readback of the entry just written (optional)
// CFG_RB_REL | waiting for done to drop after readback (optional)
// IDLE       | configured, waiting for a drdy fall
// RD_REQ     | sample read in flight
// RD_REL     | waiting for done to drop after a read
// ERROR      | transfer timed out; left only by reset
module ecg_afe_sequencer
    import ecg_afe_pkg::*;
#(
    parameter int          PWRUP_CYCLES   = 100000,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter int          NUM_CFG        = 4,
    parameter logic [31:0] READ_CMD       = READ_CMD_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       drdy_n,
    ecg_afe_sequencer_if.master        spi,
    output logic                       cfg_done,
    output logic                       sample_valid,
    output logic [23:0]                sample_data,
    output logic [7:0]                 sample_status,
    output logic                       overrun,
    output logic                       timeout_err,
    output logic                       cfg_err
);
    localparam int PW = $clog2(PWRUP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_t    state;
    logic [PW-1:0] pwr_cnt;
    logic [TW-1:0] to_cnt;
    logic [3:0]    idx;
    logic          pending;
    logic          fall;
    logic          start_q;
    logic [31:0]   tx_q;
    logic          req_wait;
    logic          to_hit;
    logic          cfg_busy;
    logic          last_cfg;

    ecg_drdy_sync u_drdy_sync (
        .clk    (clk),
        .rst    (rst),
        .drdy_n (drdy_n),
        .fall   (fall)
    );

    assign spi.spi_start   = start_q;
    assign spi.spi_tx_data = tx_q;

    assign req_wait = start_q && !spi.spi_done;
    assign to_hit   = req_wait && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign last_cfg = (idx == 4'(NUM_CFG - 1));
`ifdef ECG_SEQ_READBACK_EN
    logic [31:0] cur_cfg;
    assign cur_cfg  = cfg_table(idx);
    assign cfg_busy = (state == S_CFG_REQ) || (state == S_CFG_REL) ||
                      (state == S_CFG_RB_REQ) || (state == S_CFG_RB_REL);
`else
    assign cfg_busy = (state == S_CFG_REQ) || (state == S_CFG_REL);
    assign cfg_err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_PWRUP;
            pwr_cnt       <= '0;
            to_cnt        <= '0;
            idx           <= '0;
            pending       <= 1'b0;
            start_q       <= 1'b0;
            tx_q          <= '0;
            cfg_done      <= 1'b0;
            sample_valid  <= 1'b0;
            sample_data   <= '0;
            sample_status <= '0;
            overrun       <= 1'b0;
            timeout_err   <= 1'b0;
`ifdef ECG_SEQ_READBACK_EN
            cfg_err       <= 1'b0;
`endif
        end else begin
            sample_valid <= 1'b0;
            to_cnt       <= req_wait ? to_cnt + 1'b1 : '0;
            if (fall && cfg_busy)
                overrun <= 1'b1;

            if (to_hit) begin
                timeout_err <= 1'b1;
                start_q     <= 1'b0;
                state       <= S_ERROR;
            end else begin
                case (state)
                    S_PWRUP: begin
                        if (pwr_cnt == PW'(PWRUP_CYCLES - 1)) begin
                            idx     <= '0;
                            tx_q    <= cfg_table(4'd0);
                            start_q <= 1'b1;
                            state   <= S_CFG_REQ;
                        end else begin
                            pwr_cnt <= pwr_cnt + 1'b1;
                        end
                    end
                    S_CFG_REQ: begin
                        if (spi.spi_done) begin
                            start_q <= 1'b0;
                            state   <= S_CFG_REL;
                        end
                    end
`ifdef ECG_SEQ_READBACK_EN
                    S_CFG_REL: begin
                        if (!spi.spi_done) begin
                            tx_q    <= rreg_cmd(cur_cfg[28:24]);
                            start_q <= 1'b1;
                            state   <= S_CFG_RB_REQ;
                        end
                    end
                    S_CFG_RB_REQ: begin
                        if (spi.spi_done) begin
                            if (spi.spi_rx_data[7:0] != cur_cfg[15:8])
                                cfg_err <= 1'b1;
                            start_q <= 1'b0;
                            state   <= S_CFG_RB_REL;
                        end
                    end
                    S_CFG_RB_REL: begin
`else
                    S_CFG_REL: begin
`endif
                        if (!spi.spi_done) begin
                            if (last_cfg) begin
                                cfg_done <= 1'b1;
                                state    <= S_IDLE;
                            end else begin
                                idx     <= idx + 4'd1;
                                tx_q    <= cfg_table(idx + 4'd1);
                                start_q <= 1'b1;
                                state   <= S_CFG_REQ;
                            end
                        end
                    end
                    S_IDLE: begin
                        if (fall && enable) begin
                            tx_q    <= READ_CMD;
                            start_q <= 1'b1;
                            state   <= S_RD_REQ;
                        end
                    end
                    S_RD_REQ: begin
                        if (fall) begin
                            if (pending) overrun <= 1'b1;
                            else         pending <= 1'b1;
                        end
                        if (spi.spi_done) begin
                            sample_data   <= spi.spi_rx_data[23:0];
                            sample_status <= spi.spi_rx_data[31:24];
                            sample_valid  <= 1'b1;
                            start_q       <= 1'b0;
                            state         <= S_RD_REL;
                        end
                    end
                    S_RD_REL: begin
                        if (!spi.spi_done) begin
                            // A fall arriving on the exit cycle either starts the
                            // next read itself or becomes the new pending event.
                            if ((pending || fall) && enable) begin
                                pending <= pending && fall;
                                tx_q    <= READ_CMD;
                                start_q <= 1'b1;
                                state   <= S_RD_REQ;
                            end else begin
                                pending <= 1'b0;
                                state   <= S_IDLE;
                            end
                        end else if (fall) begin
                            if (pending) overrun <= 1'b1;
                            else         pending <= 1'b1;
                        end
                    end
                    S_ERROR: begin
                        start_q <= 1'b0;
                    end
                    default: begin
                        start_q <= 1'b0;
                        state   <= S_ERROR;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ecg_afe_sequencer.sv
// Directed bench for ecg_afe_sequencer with a scoreboarded SPI master model.
module tb_ecg_afe_sequencer;
    logic        clk;
    logic        rst;
    logic        enable;
    logic        drdy_n;
    logic        cfg_done;
    logic        sample_valid;
    logic [23:0] sample_data;
    logic [7:0]  sample_status;
    logic        overrun;
    logic        timeout_err;
    logic        cfg_err;

    localparam logic [31:0] READ_CMD = 32'h1200_0000;
    localparam logic [31:0] CFG_W0 = 32'h4100_0200;
    localparam logic [31:0] CFG_W1 = 32'h4200_A000;
    localparam logic [31:0] CFG_W2 = 32'h4400_0500;
    localparam logic [31:0] CFG_W3 = 32'h4500_8100;
`ifdef ECG_SEQ_READBACK_EN
    localparam int  CFG_XFERS = 8;
    localparam logic EXP_CFG_ERR = 1'b1;
`else
    localparam int  CFG_XFERS = 4;
    localparam logic EXP_CFG_ERR = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    int xfer_cnt = 0;
    int sv_cnt = 0;
    int rise_cnt = 0;
    int resp_delay = 20;
    bit hang = 0;

    logic [31:0] exp_tx[$];
    logic [31:0] resp_q[$];
    logic [31:0] exp_smp[$];

    ecg_afe_sequencer_if spi_bus ();

    ecg_afe_sequencer #(
        .PWRUP_CYCLES   (16),
        .TIMEOUT_CYCLES (64),
        .NUM_CFG        (4),
        .READ_CMD       (READ_CMD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .drdy_n        (drdy_n),
        .spi           (spi_bus.master),
        .cfg_done      (cfg_done),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .sample_status (sample_status),
        .overrun       (overrun),
        .timeout_err   (timeout_err),
        .cfg_err       (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_xfer(input logic [31:0] tx, input logic [31:0] rx);
        exp_tx.push_back(tx);
        resp_q.push_back(rx);
    endtask

    task automatic push_read(input logic [31:0] rx);
        push_xfer(READ_CMD, rx);
        exp_smp.push_back(rx);
    endtask

    task automatic push_cfg();
        logic [31:0] w [4];
        w = '{CFG_W0, CFG_W1, CFG_W2, CFG_W3};
        for (int i = 0; i < 4; i++) begin
            push_xfer(w[i], 32'h0);
`ifdef ECG_SEQ_READBACK_EN
            push_xfer({8'h20 | {3'b000, w[i][28:24]}, 24'h0},
                      {24'h0, (i == 2) ? 8'h00 : w[i][15:8]});
`endif
        end
    endtask

    task automatic drdy_fall();
        drdy_n = 1'b0;
        repeat (3) @(negedge clk);
        drdy_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_sv(input int target, input string tag);
        int n = 0;
        while (sv_cnt < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, sv_cnt >= target, 1);
    endtask

    task automatic release_and_config(input string tag);
        int x0;
        int n;
        @(negedge clk);
        rst = 1'b0;
        x0 = xfer_cnt;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (k == 15) chk({tag, "_start_low_15"}, spi_bus.spi_start, 0);
            if (k == 16) chk({tag, "_start_high_16"}, spi_bus.spi_start, 1);
        end
        n = 0;
        while (!cfg_done && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_cfg_done"}, cfg_done, 1);
        chk({tag, "_done_low_at_cfg_done"}, spi_bus.spi_done, 0);
        chk({tag, "_cfg_xfers"}, xfer_cnt - x0, CFG_XFERS);
        chk({tag, "_cfg_queue_empty"}, exp_tx.size(), 0);
        chk({tag, "_cfg_err"}, cfg_err, EXP_CFG_ERR);
    endtask

    // SPI master model: accepts a request, answers after resp_delay cycles.
    initial begin : spi_model
        logic [31:0] m_tx;
        logic [31:0] m_rx;
        int          m_wait;
        bit          m_busy;
        spi_bus.spi_done    = 1'b0;
        spi_bus.spi_rx_data = '0;
        m_busy = 0;
        m_wait = 0;
        m_tx   = '0;
        m_rx   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                spi_bus.spi_done = 1'b0;
                m_busy = 0;
            end else if (spi_bus.spi_done) begin
                if (!spi_bus.spi_start) spi_bus.spi_done = 1'b0;
            end else if (m_busy) begin
                if (!spi_bus.spi_start) begin
                    m_busy = 0;
                end else begin
                    chk("tx_stable", spi_bus.spi_tx_data, m_tx);
                    if (m_wait != 0) begin
                        m_wait--;
                    end else if (!hang) begin
                        spi_bus.spi_rx_data = m_rx;
                        spi_bus.spi_done    = 1'b1;
                        m_busy = 0;
                    end
                end
            end else if (spi_bus.spi_start) begin
                xfer_cnt++;
                m_tx = spi_bus.spi_tx_data;
                chk("xfer_expected", exp_tx.size() != 0, 1);
                if (exp_tx.size() != 0) begin
                    chk("tx_word", m_tx, exp_tx.pop_front());
                    m_rx = resp_q.pop_front();
                end
                m_busy = 1;
                m_wait = resp_delay;
            end
        end
    end

    initial begin : sample_mon
        logic        prev_sv;
        logic [31:0] e;
        logic        prev_start;
        prev_sv    = 1'b0;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (!prev_start && spi_bus.spi_start) rise_cnt++;
            prev_start = spi_bus.spi_start;
            if (rst) begin
                prev_sv = 1'b0;
            end else begin
                if (sample_valid) begin
                    sv_cnt++;
                    chk("sv_not_consecutive", prev_sv, 0);
                    chk("sv_expected", exp_smp.size() != 0, 1);
                    if (exp_smp.size() != 0) begin
                        e = exp_smp.pop_front();
                        chk("sample_status", sample_status, e[31:24]);
                        chk("sample_data", sample_data, e[23:0]);
                    end
                end
                prev_sv = sample_valid;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int x0;
        int s0;
        int r0;
        int n;
        rst    = 1'b1;
        enable = 1'b1;
        drdy_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", spi_bus.spi_tx_data, 0);
        chk("rst_outputs", {spi_bus.spi_start, cfg_done, sample_valid, sample_data,
                            sample_status, overrun, timeout_err, cfg_err}, 0);

        push_cfg();
        release_and_config("boot");

        // Single read
        push_read(32'hA512_3456);
        x0 = xfer_cnt;
        s0 = sv_cnt;
        drdy_fall();
        wait_sv(s0 + 1, "single_sv");
        repeat (30) @(negedge clk);
        chk("single_reads", xfer_cnt - x0, 1);
        chk("single_overrun", overrun, 0);
        chk("single_hold_data", sample_data, 24'h123456);
        chk("single_hold_status", sample_status, 8'hA5);

        // Falls with enable low are ignored
        enable = 1'b0;
        x0 = xfer_cnt;
        drdy_fall();
        repeat (40) @(negedge clk);
        chk("disabled_no_read", xfer_cnt - x0, 0);
        chk("disabled_overrun", overrun, 0);
        enable = 1'b1;

        // One fall during a read: back-to-back second read
        push_read(32'h3C00_0001);
        push_read(32'h3D7F_FFFF);
        x0 = xfer_cnt;
        s0 = sv_cnt;
        drdy_fall();
        drdy_fall();
        wait_sv(s0 + 2, "b2b_sv");
        repeat (40) @(negedge clk);
        chk("b2b_reads", xfer_cnt - x0, 2);
        chk("b2b_overrun", overrun, 0);
        chk("b2b_queue_empty", exp_tx.size(), 0);

        // Two falls during a read: one pending, one dropped as overrun
        push_read(32'h0180_0000);
        push_read(32'hFF00_00FF);
        x0 = xfer_cnt;
        s0 = sv_cnt;
        drdy_fall();
        drdy_fall();
        drdy_fall();
        wait_sv(s0 + 2, "ovr_sv");
        repeat (60) @(negedge clk);
        chk("ovr_reads", xfer_cnt - x0, 2);
        chk("ovr_overrun", overrun, 1);
        chk("ovr_queue_empty", exp_tx.size(), 0);

        // Reset in the middle of RD_REQ
        push_read(32'h1111_1111);
        drdy_n = 1'b0;
        n = 0;
        while (!spi_bus.spi_start && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mid_start_seen", spi_bus.spi_start, 1);
        drdy_n = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", spi_bus.spi_tx_data, 0);
        chk("mid_rst_outputs", {spi_bus.spi_start, cfg_done, sample_valid, sample_data,
                                sample_status, overrun, timeout_err, cfg_err}, 0);
        repeat (3) @(negedge clk);
        exp_tx.delete();
        resp_q.delete();
        exp_smp.delete();
        push_cfg();
        release_and_config("rerun");

        // Timeout: model never answers
        hang = 1;
        push_xfer(READ_CMD, 32'h0);
        drdy_n = 1'b0;
        n = 0;
        while (!spi_bus.spi_start && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("to_start_seen", spi_bus.spi_start, 1);
        drdy_n = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            if (k == 63) begin
                chk("to_err_low_63", timeout_err, 0);
                chk("to_start_high_63", spi_bus.spi_start, 1);
            end
            if (k == 64) begin
                chk("to_err_high_64", timeout_err, 1);
                chk("to_start_low_64", spi_bus.spi_start, 0);
            end
        end
        x0 = xfer_cnt;
        r0 = rise_cnt;
        drdy_fall();
        drdy_fall();
        repeat (40) @(negedge clk);
        chk("err_no_rise", rise_cnt - r0, 0);
        chk("err_no_xfer", xfer_cnt - x0, 0);
        chk("err_sticky", timeout_err, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
